// File: rtl/bcd_rx_pkg.sv
// Shared types and constants for the BCD-sequenced serial pattern receiver.
package bcd_rx_pkg;

    typedef enum logic [1:0] {
        FILL = 2'd0,
        HUNT = 2'd1,
        LOCK = 2'd2
    } rx_state_e;

    localparam int FRAME_LEN = 10;
    localparam logic [3:0] BCD_MAX = 4'd9;
    localparam logic [FRAME_LEN-1:0] DEFAULT_PATTERN = 10'b0000111111;

    // Fill count seen on the 9th sample; the 10th sample is evaluated in HUNT.
    localparam logic [3:0] FILL_LAST = 4'(FRAME_LEN - 2);

endpackage

// File: rtl/bcd_digit_counter.sv
// Single BCD digit counter (0..9 wrap) with synchronous clear and enable.
module bcd_digit_counter
    import bcd_rx_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr,
    input  logic       en,
    output logic [3:0] cnt
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= 4'd0;
        end else if (clr) begin
            cnt <= 4'd0;
        end else if (en) begin
            cnt <= (cnt == BCD_MAX) ? 4'd0 : cnt + 4'd1;
        end
    end

endmodule

// File: rtl/bcd_pattern_rx.sv
// Serial frame receiver: finds 10-bit frame alignment, tracks BCD bit position,
// checks each frame. Define BCD_RX_ERRCNT_EN to build the saturating err_cnt counter.
//
// state | meaning
// FILL  | shift register filling after reset, no evaluation yet
// HUNT  | sliding-window search for the pattern every cycle
// LOCK  | aligned; frame checked when position 9 is sampled
module bcd_pattern_rx
    import bcd_rx_pkg::*;
#(
    parameter logic [FRAME_LEN-1:0] PATTERN     = DEFAULT_PATTERN,
    parameter int                   LOSS_THRESH = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sdi,
    output logic       locked,
    output logic [3:0] pos,
    output logic       frame_ok,
    output logic       frame_err,
    output logic [7:0] err_cnt
);

    localparam logic [3:0] LOSS_THRESH_W = 4'(LOSS_THRESH);

    rx_state_e            state_q;
    rx_state_e            state_d;
    // SR[0] falls out of the window on every sample, so only SR[9:1] is kept.
    logic [FRAME_LEN-2:0] sr_q;
    logic [FRAME_LEN-1:0] window;
    logic                 frame_match;
    logic [3:0]           fill_cnt;
    logic [3:0]           pos_cnt;
    logic [3:0]           bad_q;
    logic [3:0]           bad_d;
    logic [3:0]           bad_inc;
    logic                 ok_d;
    logic                 err_d;

    assign window      = {sdi, sr_q};
    assign frame_match = (window == PATTERN);
    assign bad_inc     = bad_q + 4'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr_q <= '0;
        end else begin
            sr_q <= window[FRAME_LEN-1:1];
        end
    end

    bcd_digit_counter u_fill_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (state_q != FILL),
        .en    (state_q == FILL),
        .cnt   (fill_cnt)
    );

    // Wraps 9->0 on its own, so leaving LOCK on loss already lands at 0.
    bcd_digit_counter u_pos_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (state_q != LOCK),
        .en    (state_q == LOCK),
        .cnt   (pos_cnt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= FILL;
            bad_q     <= 4'd0;
            frame_ok  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            state_q   <= state_d;
            bad_q     <= bad_d;
            frame_ok  <= ok_d;
            frame_err <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        bad_d   = bad_q;
        ok_d    = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            FILL: begin
                if (fill_cnt == FILL_LAST) begin
                    state_d = HUNT;
                end
            end
            HUNT: begin
                if (frame_match) begin
                    state_d = LOCK;
                    ok_d    = 1'b1;
                    bad_d   = 4'd0;
                end
            end
            LOCK: begin
                if (pos_cnt == BCD_MAX) begin
                    if (frame_match) begin
                        ok_d  = 1'b1;
                        bad_d = 4'd0;
                    end else begin
                        err_d = 1'b1;
                        if (bad_inc == LOSS_THRESH_W) begin
                            state_d = HUNT;
                            bad_d   = 4'd0;
                        end else begin
                            bad_d = bad_inc;
                        end
                    end
                end
            end
            default: begin
                state_d = FILL;
            end
        endcase
    end

    assign locked = (state_q == LOCK);
    assign pos    = locked ? pos_cnt : 4'd0;

`ifdef BCD_RX_ERRCNT_EN
    logic [7:0] err_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt_q <= 8'd0;
        end else if (err_d && (err_cnt_q != 8'hFF)) begin
            err_cnt_q <= err_cnt_q + 8'd1;
        end
    end

    assign err_cnt = err_cnt_q;
`else
    assign err_cnt = 8'd0;
`endif

endmodule
